// File: rtl/icache_fetch_tracker.sv
// Fetch <-> ICache request tracker: in-order FIFO of issued vaddrs that selects the
// instruction slice of each returned line and silently drops responses of killed fetches.
module icache_fetch_tracker #(
   parameter int VADDR_W         = 40,
   parameter int LINE_W          = 128,
   parameter int INSTR_W         = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 fetch_valid_i,
   input  logic [VADDR_W-1:0]                   fetch_vaddr_i,
   input  logic                                 fetch_kill_i,
   input  logic                                 fetch_inval_buffer_i,
   input  logic                                 fetch_inval_icache_i,
   input  logic                                 icache_req_ready_i,
   input  logic                                 icache_resp_valid_i,
   input  logic [LINE_W-1:0]                    icache_resp_data_i,
   input  logic                                 tlb_xcpt_i,
   output logic                                 icache_req_valid_o,
   output logic [11:0]                          icache_req_idx_o,
   output logic [VADDR_W-13:0]                  icache_req_vpn_o,
   output logic                                 icache_req_kill_o,
   output logic                                 icache_invalidate_o,
   output logic                                 req_ready_o,
   output logic                                 resp_valid_o,
   output logic [INSTR_W-1:0]                   resp_data_o,
   output logic [VADDR_W-1:0]                   resp_vaddr_o,
   output logic                                 resp_pf_o,
   output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
   output logic                                 proto_err_o
);

   localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
   localparam int OFF_LO = $clog2(INSTR_W / 8);
   localparam int OFF_W  = $clog2(LINE_W / INSTR_W);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(MAX_OUTSTANDING);

   // Explicit wrap keeps the pointers modulo the depth even when the depth is 1.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      next_ptr = (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
   endfunction

   logic [VADDR_W-1:0] fifo_r [MAX_OUTSTANDING];
   logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0]   count_r, drop_r;
   logic               proto_err_r;

   logic [CNT_W-1:0]   occ_s, base_cnt_s, base_drop_s, count_nxt_s, drop_nxt_s;
   logic               full_s, rsp_s, issue_s, drop_pop_s, live_pop_s, resp_valid_s;
   logic [VADDR_W-1:0] head_s;
   logic [OFF_W-1:0]   off_s;

   // Issue/response decode and next-state of the live and drop counters.
   always_comb begin
      occ_s        = count_r + drop_r;
      full_s       = (occ_s == DEPTH);
      rsp_s        = icache_resp_valid_i | tlb_xcpt_i;
      issue_s      = fetch_valid_i & ~fetch_inval_buffer_i & ~fetch_kill_i &
                     icache_req_ready_i & ~full_s;
      drop_pop_s   = rsp_s & (drop_r != {CNT_W{1'b0}});
      live_pop_s   = rsp_s & (drop_r == {CNT_W{1'b0}}) & (count_r != {CNT_W{1'b0}});
      resp_valid_s = live_pop_s & ~fetch_kill_i;
      head_s       = fifo_r[rd_ptr_r];
      off_s        = head_s[OFF_LO +: OFF_W];
      base_cnt_s   = count_r + CNT_W'(issue_s) - CNT_W'(live_pop_s);
      base_drop_s  = drop_r - CNT_W'(drop_pop_s);
      // A kill turns every surviving live entry into a future drop.
      count_nxt_s  = fetch_kill_i ? {CNT_W{1'b0}} : base_cnt_s;
      drop_nxt_s   = fetch_kill_i ? (base_drop_s + base_cnt_s) : base_drop_s;
   end

   // Tracking FIFO storage; contents need no reset since the counters qualify them.
   always_ff @(posedge clk_i) begin
      if (issue_s) begin
         fifo_r[wr_ptr_r] <= fetch_vaddr_i;
      end
   end

   // Pointers, counters and sticky protocol error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         drop_r      <= {CNT_W{1'b0}};
         proto_err_r <= 1'b0;
      end else begin
         if (issue_s) begin
            wr_ptr_r <= next_ptr(wr_ptr_r);
         end
         if (drop_pop_s | live_pop_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
         if (rsp_s & ~(drop_pop_s | live_pop_s)) begin
            proto_err_r <= 1'b1;
         end
         count_r <= count_nxt_s;
         drop_r  <= drop_nxt_s;
      end
   end

   assign icache_req_valid_o  = issue_s;
   assign icache_req_idx_o    = fetch_vaddr_i[11:0];
   assign icache_req_vpn_o    = fetch_vaddr_i[VADDR_W-1:12];
   assign icache_req_kill_o   = fetch_kill_i;
   assign icache_invalidate_o = fetch_inval_icache_i;
   assign req_ready_o         = icache_req_ready_i & ~full_s;
   assign resp_valid_o        = resp_valid_s;
   assign resp_vaddr_o        = head_s;
   assign resp_pf_o           = resp_valid_s & tlb_xcpt_i;
   assign resp_data_o         = tlb_xcpt_i ? {INSTR_W{1'b0}}
                                           : icache_resp_data_i[int'(off_s) * INSTR_W +: INSTR_W];
   assign outstanding_o       = count_r;
   assign proto_err_o         = proto_err_r;

endmodule

// File: tb/tb_icache_fetch_tracker.sv
// Directed plus randomized bench for icache_fetch_tracker; a queue model of in-flight
// fetches (each tagged live or killed) predicts every output. A 256-bit-line twin checks slicing.
module tb_icache_fetch_tracker;

   localparam int VA_W = 40;
   localparam int MAXO = 2;
   localparam int IW   = 32;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            fetch_valid_i, fetch_kill_i, fetch_inval_buffer_i, fetch_inval_icache_i;
   logic [VA_W-1:0] fetch_vaddr_i;
   logic            icache_req_ready_i, icache_resp_valid_i, tlb_xcpt_i;
   logic [127:0]    line_a;
   logic [255:0]    line_b;

   logic            req_valid_a, req_kill_a, inval_a, req_ready_a, resp_valid_a, resp_pf_a, proto_err_a;
   logic [11:0]     req_idx_a;
   logic [VA_W-13:0] req_vpn_a;
   logic [IW-1:0]   resp_data_a;
   logic [VA_W-1:0] resp_vaddr_a;
   logic [1:0]      outst_a;

   logic            req_valid_b, req_kill_b, inval_b, req_ready_b, resp_valid_b, resp_pf_b, proto_err_b;
   logic [11:0]     req_idx_b;
   logic [VA_W-13:0] req_vpn_b;
   logic [IW-1:0]   resp_data_b;
   logic [VA_W-1:0] resp_vaddr_b;
   logic [1:0]      outst_b;

   icache_fetch_tracker #(.VADDR_W(VA_W), .LINE_W(128), .INSTR_W(IW), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk), .rst_i(rst_i), .fetch_valid_i(fetch_valid_i), .fetch_vaddr_i(fetch_vaddr_i),
      .fetch_kill_i(fetch_kill_i), .fetch_inval_buffer_i(fetch_inval_buffer_i),
      .fetch_inval_icache_i(fetch_inval_icache_i), .icache_req_ready_i(icache_req_ready_i),
      .icache_resp_valid_i(icache_resp_valid_i), .icache_resp_data_i(line_a), .tlb_xcpt_i(tlb_xcpt_i),
      .icache_req_valid_o(req_valid_a), .icache_req_idx_o(req_idx_a), .icache_req_vpn_o(req_vpn_a),
      .icache_req_kill_o(req_kill_a), .icache_invalidate_o(inval_a), .req_ready_o(req_ready_a),
      .resp_valid_o(resp_valid_a), .resp_data_o(resp_data_a), .resp_vaddr_o(resp_vaddr_a),
      .resp_pf_o(resp_pf_a), .outstanding_o(outst_a), .proto_err_o(proto_err_a));

   icache_fetch_tracker #(.VADDR_W(VA_W), .LINE_W(256), .INSTR_W(IW), .MAX_OUTSTANDING(MAXO)) dut_wide (
      .clk_i(clk), .rst_i(rst_i), .fetch_valid_i(fetch_valid_i), .fetch_vaddr_i(fetch_vaddr_i),
      .fetch_kill_i(fetch_kill_i), .fetch_inval_buffer_i(fetch_inval_buffer_i),
      .fetch_inval_icache_i(fetch_inval_icache_i), .icache_req_ready_i(icache_req_ready_i),
      .icache_resp_valid_i(icache_resp_valid_i), .icache_resp_data_i(line_b), .tlb_xcpt_i(tlb_xcpt_i),
      .icache_req_valid_o(req_valid_b), .icache_req_idx_o(req_idx_b), .icache_req_vpn_o(req_vpn_b),
      .icache_req_kill_o(req_kill_b), .icache_invalidate_o(inval_b), .req_ready_o(req_ready_b),
      .resp_valid_o(resp_valid_b), .resp_data_o(resp_data_b), .resp_vaddr_o(resp_vaddr_b),
      .resp_pf_o(resp_pf_b), .outstanding_o(outst_b), .proto_err_o(proto_err_b));

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: in-flight fetches in issue order, each flagged killed or live.
   logic [VA_W-1:0] mq[$];
   bit              mk[$];
   bit              m_err;

   logic        obs_issue, obs_ready, obs_rv, obs_pf;
   logic [31:0] obs_data, obs_data_b;
   logic [1:0]  obs_outst;
   logic        obs_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int live_cnt();
      int n = 0;
      foreach (mk[i]) if (!mk[i]) n++;
      return n;
   endfunction

   function automatic logic [31:0] word_of(input logic [255:0] line, input int line_bytes,
                                           input logic [VA_W-1:0] va);
      logic [255:0] tmp;
      int k;
      k   = int'(va % VA_W'(line_bytes)) / 4;
      tmp = line >> (IW * k);
      return tmp[31:0];
   endfunction

   // One clock cycle: inputs applied at negedge, outputs checked 1 time unit later.
   task automatic step(input logic fv, input logic [VA_W-1:0] va, input logic kill, input logic ib,
                       input logic ii, input logic rdy, input logic rv, input logic tx, input logic r);
      bit exp_ready, exp_issue, rsp, exp_rv;
      logic [31:0] exp_d;
      rst_i = r; fetch_valid_i = fv; fetch_vaddr_i = va; fetch_kill_i = kill;
      fetch_inval_buffer_i = ib; fetch_inval_icache_i = ii; icache_req_ready_i = rdy;
      icache_resp_valid_i = rv; tlb_xcpt_i = tx;
      #1;
      exp_ready = rdy && (mq.size() < MAXO);
      exp_issue = fv && !ib && !kill && exp_ready;
      rsp       = rv || tx;
      exp_rv    = rsp && !kill && ((mq.size() > 0) ? !mk[0] : 1'b0);
      chk("req_valid", req_valid_a, exp_issue);
      chk("req_ready", req_ready_a, exp_ready);
      chk("req_idx", req_idx_a, 64'(va[11:0]));
      chk("req_vpn", req_vpn_a, 64'(va >> 12));
      chk("req_kill", req_kill_a, kill);
      chk("invalidate", inval_a, ii);
      chk("resp_valid", resp_valid_a, exp_rv);
      chk("resp_valid_wide", resp_valid_b, exp_rv);
      chk("outstanding", outst_a, 64'(live_cnt()));
      chk("proto_err", proto_err_a, m_err);
      if (exp_rv) begin
         chk("resp_vaddr", resp_vaddr_a, mq[0]);
         chk("resp_pf", resp_pf_a, tx);
         exp_d = tx ? 32'h0 : word_of({128'h0, line_a}, 16, mq[0]);
         chk("resp_data", resp_data_a, exp_d);
         exp_d = tx ? 32'h0 : word_of(line_b, 32, mq[0]);
         chk("resp_data_wide", resp_data_b, exp_d);
      end
      obs_issue = req_valid_a; obs_ready = req_ready_a; obs_rv = resp_valid_a;
      obs_pf = resp_pf_a; obs_data = resp_data_a; obs_data_b = resp_data_b;
      obs_outst = outst_a; obs_err = proto_err_a;
      @(posedge clk);
      if (r) begin
         mq.delete(); mk.delete(); m_err = 1'b0;
      end else begin
         if (rsp) begin
            if (mq.size() > 0) begin
               void'(mq.pop_front()); void'(mk.pop_front());
            end else begin
               m_err = 1'b1;
            end
         end
         if (exp_issue) begin
            mq.push_back(va); mk.push_back(1'b0);
         end
         if (kill) foreach (mk[i]) mk[i] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic issue(input logic [VA_W-1:0] va);
      step(1'b1, va, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic resp(input logic rv, input logic tx);
      step(1'b0, 40'h0, 1'b0, 1'b0, 1'b0, 1'b1, rv, tx, 1'b0);
   endtask

   initial begin
      logic [VA_W-1:0] rva;
      int r;
      m_err = 1'b0;
      rst_i = 1'b1; fetch_valid_i = 1'b0; fetch_vaddr_i = '0; fetch_kill_i = 1'b0;
      fetch_inval_buffer_i = 1'b0; fetch_inval_icache_i = 1'b0; icache_req_ready_i = 1'b0;
      icache_resp_valid_i = 1'b0; tlb_xcpt_i = 1'b0; line_a = '0; line_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      chk("rst_outstanding", outst_a, 64'h0);
      chk("rst_proto_err", proto_err_a, 64'h0);
      @(negedge clk);

      // Two back-to-back issues fill the FIFO; the third stalls; data returns in order.
      line_a = 128'h00000044_00000033_00000022_00000011;
      issue(40'h1000);
      chk("t1_issue0", obs_issue, 64'h1);
      issue(40'h1004);
      issue(40'h1008);
      chk("t1_stall_ready", obs_ready, 64'h0);
      chk("t1_stall_issue", obs_issue, 64'h0);
      resp(1'b1, 1'b0);
      chk("t1_instr0", obs_data, 64'h11);
      resp(1'b1, 1'b0);
      chk("t1_instr1", obs_data, 64'h22);

      // Slice selection at the top word of 128- and 256-bit lines.
      issue(40'h100C);
      resp(1'b1, 1'b0);
      chk("t2_top128", obs_data, 64'h44);
      line_b = {32'hCAFE0007, 224'h0};
      issue(40'h101C);
      resp(1'b1, 1'b0);
      chk("t2_top256", obs_data_b, 64'hCAFE0007);

      // Kill with two in flight: both late responses vanish; the next fetch is served.
      issue(40'h1000);
      issue(40'h1004);
      step(1'b0, 40'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      resp(1'b1, 1'b0);
      chk("t3_outst_after_kill", obs_outst, 64'h0);
      chk("t3_drop0", obs_rv, 64'h0);
      resp(1'b1, 1'b0);
      chk("t3_drop1", obs_rv, 64'h0);
      issue(40'h2000);
      resp(1'b1, 1'b0);
      chk("t3_new_valid", obs_rv, 64'h1);
      chk("t3_new_data", obs_data, 64'h11);

      // Fault and line in the same cycle: one pop, fault reported, data zero.
      issue(40'h3000);
      resp(1'b1, 1'b1);
      chk("t4_pf", obs_pf, 64'h1);
      chk("t4_data", obs_data, 64'h0);
      resp(1'b0, 1'b0);
      chk("t4_single_pop", obs_outst, 64'h0);
      chk("t4_no_err", obs_err, 64'h0);

      // Kill coinciding with a response and a fetch.
      issue(40'h4000);
      issue(40'h4004);
      step(1'b1, 40'h4008, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t5_suppressed", obs_rv, 64'h0);
      chk("t5_no_issue", obs_issue, 64'h0);
      resp(1'b1, 1'b0);
      chk("t5_dropped", obs_rv, 64'h0);
      issue(40'h5004);
      resp(1'b1, 1'b0);
      chk("t5_new_data", obs_data, 64'h22);
      resp(1'b0, 1'b0);
      chk("t5_no_err", obs_err, 64'h0);

      // Response on an empty FIFO is sticky until reset; reset clears in-flight state.
      resp(1'b1, 1'b0);
      resp(1'b0, 1'b0);
      chk("t6_err_set", obs_err, 64'h1);
      issue(40'h6000);
      issue(40'h6004);
      chk("t6_err_sticky", obs_err, 64'h1);
      step(1'b0, 40'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      resp(1'b0, 1'b0);
      chk("t6_rst_outst", obs_outst, 64'h0);
      chk("t6_rst_err", obs_err, 64'h0);

      // Randomized traffic; the ICache only answers while something is in flight.
      for (int n = 0; n < 800; n++) begin
         r = int'($urandom);
         line_a = {$urandom, $urandom, $urandom, $urandom};
         line_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         rva = {8'($urandom), $urandom} & ~40'h3;
         step(($urandom % 4) != 0, rva, ($urandom % 12) == 0, ($urandom % 8) == 0,
              ($urandom % 8) == 0, ($urandom % 4) != 0,
              (mq.size() > 0) && (r % 2 == 0), (mq.size() > 0) && (r % 7 == 1), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
